// File: rtl/id_stage_ctrl.sv
// rtl/id_stage_ctrl.sv - LEGv8 ID-stage decode, ID/EX control register and load-use stall FSM
// Optional illegal-opcode trap enabled by defining ID_ILLEGAL_TRAP_EN.
module id_stage_ctrl #(
    parameter int          STALL_CYCLES = 1,
    parameter logic [4:0]  ZERO_REG     = 5'd31
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] InstrIn,
    input  logic        InValid,
    input  logic        Flush,
    output logic        Stall,
    output logic        ValidOut,
    output logic [2:0]  SignOp,
    output logic [25:0] Imm26,
    output logic [4:0]  Rn,
    output logic [4:0]  R2,
    output logic [4:0]  Rd,
    output logic        ALUSrc,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        MemToReg,
    output logic        Branch,
    output logic        UncondBranch,
    output logic        IllegalOp
);

    typedef enum logic {S_RUN, S_STALL} state_t;

    typedef struct packed {
        logic        valid;
        logic [2:0]  signop;
        logic        alusrc;
        logic        memread;
        logic        memwrite;
        logic        regwrite;
        logic        memtoreg;
        logic        branch;
        logic        ubranch;
        logic [25:0] imm;
        logic [4:0]  rn;
        logic [4:0]  r2;
        logic [4:0]  rd;
    } idex_t;

    localparam logic [1:0] CNT_INIT = (STALL_CYCLES > 1) ? 2'(STALL_CYCLES - 2) : 2'd0;

    state_t     r_state, w_next_state;
    logic [1:0] r_cnt, w_next_cnt;
    idex_t      r_idex, w_dec;
    logic       r_illegal;

    logic       w_known, w_reg2loc, w_uses_r2;
    logic [4:0] w_rn, w_r2;
    logic       w_hazard, w_stall, w_accept, w_load, w_illegal;

    assign w_rn = InstrIn[9:5];
    assign w_r2 = w_reg2loc ? InstrIn[4:0] : InstrIn[20:16];

    always_comb begin
        w_dec     = '0;
        w_known   = 1'b0;
        w_reg2loc = 1'b0;
        w_uses_r2 = 1'b0;
        casez (InstrIn[31:21])
            11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000: begin
                w_known = 1'b1; w_uses_r2 = 1'b1;
                w_dec.regwrite = 1'b1;
            end
            11'b1001000100?, 11'b1101000100?: begin
                w_known = 1'b1;
                w_dec.alusrc = 1'b1; w_dec.regwrite = 1'b1;
            end
            11'b11111000010: begin
                w_known = 1'b1;
                w_dec.signop = 3'b001; w_dec.alusrc = 1'b1; w_dec.memread = 1'b1;
                w_dec.regwrite = 1'b1; w_dec.memtoreg = 1'b1;
            end
            11'b11111000000: begin
                w_known = 1'b1; w_reg2loc = 1'b1; w_uses_r2 = 1'b1;
                w_dec.signop = 3'b001; w_dec.alusrc = 1'b1; w_dec.memwrite = 1'b1;
            end
            11'b000101?????: begin
                w_known = 1'b1;
                w_dec.signop = 3'b010; w_dec.ubranch = 1'b1;
            end
            11'b10110100???: begin
                w_known = 1'b1; w_reg2loc = 1'b1; w_uses_r2 = 1'b1;
                w_dec.signop = 3'b011; w_dec.branch = 1'b1;
            end
            11'b110100101??: begin
                w_known = 1'b1;
                w_dec.signop = 3'b100; w_dec.alusrc = 1'b1; w_dec.regwrite = 1'b1;
            end
            default: ;
        endcase
        if (w_known) begin
            w_dec.valid = 1'b1;
            w_dec.imm   = InstrIn[25:0];
            w_dec.rn    = w_rn;
            w_dec.r2    = w_r2;
            w_dec.rd    = InstrIn[4:0];
        end
    end

    // Hazard is checked against the load sitting in our own ID/EX register
    assign w_hazard = InValid & r_idex.valid & r_idex.memread & (r_idex.rd != ZERO_REG) &
                      ((r_idex.rd == w_rn) | (w_uses_r2 & (r_idex.rd == w_r2)));

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_stall      = 1'b0;
        if (Flush) begin
            w_next_state = S_RUN;
            w_next_cnt   = 2'd0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_hazard) begin
                        w_stall = 1'b1;
                        if (STALL_CYCLES > 1) begin
                            w_next_state = S_STALL;
                            w_next_cnt   = CNT_INIT;
                        end
                    end
                end
                S_STALL: begin
                    w_stall = 1'b1;
                    if (r_cnt == 2'd0) w_next_state = S_RUN;
                    else               w_next_cnt   = r_cnt - 2'd1;
                end
                default: w_next_state = S_RUN;
            endcase
        end
    end

    assign w_accept = InValid & ~w_stall & ~Flush;
    assign w_load   = w_accept & w_known;
`ifdef ID_ILLEGAL_TRAP_EN
    assign w_illegal = w_accept & ~w_known;
`else
    assign w_illegal = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state   <= S_RUN;
            r_cnt     <= 2'd0;
            r_idex    <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_cnt     <= w_next_cnt;
            r_idex    <= w_load ? w_dec : '0;
            r_illegal <= w_illegal;
        end
    end

    assign Stall        = w_stall;
    assign ValidOut     = r_idex.valid;
    assign SignOp       = r_idex.signop;
    assign Imm26        = r_idex.imm;
    assign Rn           = r_idex.rn;
    assign R2           = r_idex.r2;
    assign Rd           = r_idex.rd;
    assign ALUSrc       = r_idex.alusrc;
    assign MemRead      = r_idex.memread;
    assign MemWrite     = r_idex.memwrite;
    assign RegWrite     = r_idex.regwrite;
    assign MemToReg     = r_idex.memtoreg;
    assign Branch       = r_idex.branch;
    assign UncondBranch = r_idex.ubranch;
    assign IllegalOp    = r_illegal;

endmodule

// File: tb/tb_id_stage_ctrl.sv
// tb/tb_id_stage_ctrl.sv - randomized + directed bench for id_stage_ctrl (STALL_CYCLES 1 and 3)
module tb_id_stage_ctrl;

`ifdef ID_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct packed {
        logic        valid;
        logic [2:0]  signop;
        logic        alusrc, memread, memwrite, regwrite, memtoreg, branch, ubranch;
        logic [25:0] imm;
        logic [4:0]  rn, r2, rd;
        logic        illegal;
    } idex_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [31:0] i0_instr, i1_instr;
    logic        i0_valid, i1_valid, i0_flush, i1_flush;
    logic        s0_stall, s0_v, s0_alu, s0_mr, s0_mw, s0_rw, s0_m2r, s0_br, s0_ub, s0_ill;
    logic        s1_stall, s1_v, s1_alu, s1_mr, s1_mw, s1_rw, s1_m2r, s1_br, s1_ub, s1_ill;
    logic [2:0]  s0_so, s1_so;
    logic [25:0] s0_imm, s1_imm;
    logic [4:0]  s0_rn, s0_r2, s0_rd, s1_rn, s1_r2, s1_rd;

    id_stage_ctrl #(.STALL_CYCLES(1)) dut0 (
        .CLK(clk), .Reset(rst), .InstrIn(i0_instr), .InValid(i0_valid), .Flush(i0_flush),
        .Stall(s0_stall), .ValidOut(s0_v), .SignOp(s0_so), .Imm26(s0_imm),
        .Rn(s0_rn), .R2(s0_r2), .Rd(s0_rd), .ALUSrc(s0_alu), .MemRead(s0_mr), .MemWrite(s0_mw),
        .RegWrite(s0_rw), .MemToReg(s0_m2r), .Branch(s0_br), .UncondBranch(s0_ub), .IllegalOp(s0_ill));

    id_stage_ctrl #(.STALL_CYCLES(3)) dut1 (
        .CLK(clk), .Reset(rst), .InstrIn(i1_instr), .InValid(i1_valid), .Flush(i1_flush),
        .Stall(s1_stall), .ValidOut(s1_v), .SignOp(s1_so), .Imm26(s1_imm),
        .Rn(s1_rn), .R2(s1_r2), .Rd(s1_rd), .ALUSrc(s1_alu), .MemRead(s1_mr), .MemWrite(s1_mw),
        .RegWrite(s1_rw), .MemToReg(s1_m2r), .Branch(s1_br), .UncondBranch(s1_ub), .IllegalOp(s1_ill));

    idex_t obs0, obs1;
    assign obs0 = {s0_v, s0_so, s0_alu, s0_mr, s0_mw, s0_rw, s0_m2r, s0_br, s0_ub, s0_imm, s0_rn, s0_r2, s0_rd, s0_ill};
    assign obs1 = {s1_v, s1_so, s1_alu, s1_mr, s1_mw, s1_rw, s1_m2r, s1_br, s1_ub, s1_imm, s1_rn, s1_r2, s1_rd, s1_ill};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // kinds: 0 R-type, 1 ADDI/SUBI, 2 LDUR, 3 STUR, 4 B, 5 CBZ, 6 MOVZ, 7 unknown
    logic [31:0] d_instr[2];
    int          d_kind[2];
    logic        d_valid[2], d_flush[2];
    idex_t       m_q[2], snap[2];
    int          m_left[2];
    logic        acc[2], last_stall[2];

    function automatic int nstall(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic uses_r2(input int k);
        return (k == 0) || (k == 3) || (k == 5);
    endfunction

    function automatic logic [4:0] r2_of(input int k, input logic [31:0] ins);
        return ((k == 3) || (k == 5)) ? ins[4:0] : ins[20:16];
    endfunction

    function automatic idex_t expect_of(input int k, input logic [31:0] ins);
        idex_t e;
        e = '0;
        e.valid = 1'b1; e.imm = ins[25:0]; e.rn = ins[9:5]; e.rd = ins[4:0]; e.r2 = r2_of(k, ins);
        case (k)
            0: e.regwrite = 1'b1;
            1: begin e.alusrc = 1'b1; e.regwrite = 1'b1; end
            2: begin e.signop = 3'd1; e.alusrc = 1'b1; e.memread = 1'b1; e.regwrite = 1'b1; e.memtoreg = 1'b1; end
            3: begin e.signop = 3'd1; e.alusrc = 1'b1; e.memwrite = 1'b1; end
            4: begin e.signop = 3'd2; e.ubranch = 1'b1; end
            5: begin e.signop = 3'd3; e.branch = 1'b1; end
            default: begin e.signop = 3'd4; e.alusrc = 1'b1; e.regwrite = 1'b1; end
        endcase
        return e;
    endfunction

    function automatic logic [4:0] small_reg();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 5'd31 : 5'(r);
    endfunction

    function automatic logic [31:0] gen(input int k);
        logic [31:0] w;
        logic [10:0] rops[4];
        rops = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000};
        w = $urandom;
        w[4:0] = small_reg(); w[9:5] = small_reg(); w[20:16] = small_reg();
        case (k)
            0: w[31:21] = rops[$urandom_range(0, 3)];
            1: w[31:22] = ($urandom_range(0, 1) == 1) ? 10'b1001000100 : 10'b1101000100;
            2: w[31:21] = 11'b11111000010;
            3: w[31:21] = 11'b11111000000;
            4: w[31:26] = 6'b000101;
            5: w[31:24] = 8'b10110100;
            6: w[31:23] = 9'b110100101;
            default: w[31:21] = ($urandom_range(0, 1) == 1) ? 11'h000 : 11'h7FF;
        endcase
        return w;
    endfunction

    task automatic step(input logic rs);
        @(negedge clk);
        snap[0] = obs0;
        snap[1] = obs1;
        for (int i = 0; i < 2; i++) check($sformatf("idex%0d", i), 64'(snap[i]), 64'(m_q[i]));
        rst = rs;
        i0_instr = d_instr[0]; i0_valid = d_valid[0]; i0_flush = d_flush[0];
        i1_instr = d_instr[1]; i1_valid = d_valid[1]; i1_flush = d_flush[1];
        #1;
        last_stall[0] = s0_stall;
        last_stall[1] = s1_stall;
        for (int i = 0; i < 2; i++) begin
            idex_t p, nxt;
            logic  haz, es;
            p = m_q[i]; nxt = '0; es = 1'b0;
            if (rs) begin
                m_left[i] = 0; acc[i] = 1'b0;
            end else begin
                haz = d_valid[i] && p.valid && p.memread && (p.rd != 5'd31) &&
                      ((p.rd == d_instr[i][9:5]) || (uses_r2(d_kind[i]) && (p.rd == r2_of(d_kind[i], d_instr[i]))));
                if (d_flush[i]) m_left[i] = 0;
                else if (m_left[i] > 0) begin es = 1'b1; m_left[i]--; end
                else if (haz) begin es = 1'b1; m_left[i] = nstall(i) - 1; end
                check($sformatf("stall%0d", i), 64'(last_stall[i]), 64'(es));
                acc[i] = d_valid[i] && !es && !d_flush[i];
                if (acc[i]) begin
                    if (d_kind[i] == 7) nxt.illegal = TRAP;
                    else                nxt = expect_of(d_kind[i], d_instr[i]);
                end
            end
            m_q[i] = nxt;
        end
    endtask

    task automatic idle();
        for (int i = 0; i < 2; i++) begin d_valid[i] = 1'b0; d_flush[i] = 1'b0; end
        step(1'b0);
    endtask

    task automatic issue_both(input logic [31:0] ins, input int k, output int sc0, output int sc1);
        logic pend[2];
        pend = '{1'b1, 1'b1};
        sc0 = 0; sc1 = 0;
        for (int t = 0; t < 12 && (pend[0] || pend[1]); t++) begin
            for (int i = 0; i < 2; i++) begin
                d_instr[i] = ins; d_kind[i] = k; d_valid[i] = pend[i]; d_flush[i] = 1'b0;
            end
            step(1'b0);
            if (last_stall[0]) sc0++;
            if (last_stall[1]) sc1++;
            for (int i = 0; i < 2; i++) if (acc[i]) pend[i] = 1'b0;
        end
        if (pend[0] || pend[1]) check("issue_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        int sc0, sc1;
        rst = 1'b1;
        i0_instr = '0; i1_instr = '0; i0_valid = 0; i1_valid = 0; i0_flush = 0; i1_flush = 0;
        for (int i = 0; i < 2; i++) begin
            d_instr[i] = '0; d_kind[i] = 7; d_valid[i] = 0; d_flush[i] = 0;
            m_q[i] = '0; m_left[i] = 0; acc[i] = 0; last_stall[i] = 0;
        end
        repeat (2) @(posedge clk);
        idle();
        check("reset_stall", 64'(last_stall[0]), 64'd0);

        issue_both(32'hF8400041, 2, sc0, sc1);
        idle();
        check("ldur_valid", 64'(snap[0].valid), 64'd1);
        check("ldur_signop", 64'(snap[0].signop), 64'd1);
        check("ldur_memread", 64'(snap[0].memread), 64'd1);
        check("ldur_memtoreg", 64'(snap[0].memtoreg), 64'd1);
        check("ldur_rd", 64'(snap[0].rd), 64'd1);
        check("ldur_rn", 64'(snap[0].rn), 64'd2);
        idle();

        issue_both(32'hF8400041, 2, sc0, sc1);
        issue_both(32'h8B040023, 0, sc0, sc1);
        check("ld_use_stall1", 64'(sc0), 64'd1);
        check("ld_use_stall3", 64'(sc1), 64'd3);
        idle();
        check("add_signop", 64'(snap[1].signop), 64'd0);
        check("add_alusrc", 64'(snap[1].alusrc), 64'd0);
        check("add_regwrite", 64'(snap[1].regwrite), 64'd1);
        check("add_rn", 64'(snap[1].rn), 64'd1);
        check("add_r2", 64'(snap[1].r2), 64'd4);
        idle();

        issue_both(32'hF8400041, 2, sc0, sc1);
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 2; i++) begin
                d_instr[i] = 32'h8B040023; d_kind[i] = 0; d_valid[i] = 1'b1; d_flush[i] = (t == 1);
            end
            step(1'b0);
            if (t == 1) check("flush_drops_stall", 64'(last_stall[1]), 64'd0);
        end
        idle(); idle();

        issue_both(32'hF840005F, 2, sc0, sc1);
        issue_both(32'h8B0403E3, 0, sc0, sc1);
        check("xzr_no_stall", 64'(sc0 + sc1), 64'd0);
        idle();

        issue_both(32'hF8400045, 2, sc0, sc1);
        issue_both(32'hB4000085, 5, sc0, sc1);
        check("cbz_stall1", 64'(sc0), 64'd1);
        check("cbz_stall3", 64'(sc1), 64'd3);
        idle();
        check("cbz_signop", 64'(snap[1].signop), 64'd3);
        check("cbz_branch", 64'(snap[1].branch), 64'd1);
        check("cbz_r2", 64'(snap[1].r2), 64'd5);

        issue_both(32'h14000008, 4, sc0, sc1);
        idle();
        check("b_signop", 64'(snap[0].signop), 64'd2);
        check("b_ubranch", 64'(snap[0].ubranch), 64'd1);
        check("b_imm26", 64'(snap[0].imm), 64'h8);

        for (int i = 0; i < 2; i++) begin
            d_instr[i] = 32'h14000008; d_kind[i] = 4; d_valid[i] = 1'b1; d_flush[i] = 1'b1;
        end
        step(1'b0);
        idle();
        check("flush_bubble", 64'(snap[0].valid), 64'd0);

        issue_both(32'h00000000, 7, sc0, sc1);
        idle();
        check("illegal_bubble", 64'(snap[0].valid), 64'd0);
        check("illegal_pulse", 64'(snap[0].illegal), 64'(TRAP));
        idle();

        issue_both(32'hF8400041, 2, sc0, sc1);
        for (int i = 0; i < 2; i++) begin
            d_instr[i] = 32'h8B040023; d_kind[i] = 0; d_valid[i] = 1'b1; d_flush[i] = 1'b0;
        end
        step(1'b0);
        for (int i = 0; i < 2; i++) d_valid[i] = 1'b0;
        step(1'b1);
        idle();
        check("reset_mid_stall", 64'(last_stall[1]), 64'd0);
        idle();

        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (acc[i] || !d_valid[i] || d_flush[i]) begin
                    int k;
                    k = $urandom_range(0, 9);
                    if (k > 7) k = 2;
                    d_kind[i]  = k;
                    d_instr[i] = gen(k);
                    d_valid[i] = ($urandom_range(0, 99) < 85);
                end
                d_flush[i] = ($urandom_range(0, 99) < 8);
            end
            step($urandom_range(0, 199) == 0);
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
